ast_trace_buffer: RTL
=====================

AST_TRACE_BUFFER -- requirements
Module: ast_trace_buffer

Interface
REQ-001 Parameters SHALL be, one per line (name, default, meaning):
- IW_W, 16, instruction-word width.
- PC_W, 16, program-counter width.
- DEPTH, 16, trace entries; power of 2, at least 4.
- TS_W, 16, timestamp width.
- CW = clog2(DEPTH)+1, derived, width of count fields.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- Clock_pin, in, 1, single clock; all logic on its rising edge.
- Reset_pin, in, 1, synchronous, active-high reset.
- arm, in, 1, pulse that starts a capture session.
- stop, in, 1, manual trigger pulse.
- trig_op, in, 6, opcode (IR[13:8]) that fires the trigger.
- post_cnt, in, CW, number of entries to store after the trigger.
- filter_en, in, 1, when 1, NOP (6'b111110) and STALL (6'b111111) words are not stored.
- IR, in, IW_W, retired instruction word.
- PC, in, PC_W, address of IR.
- IR_valid, in, 1, IR/PC qualifier.
- rd_ready, in, 1, readout consumer ready.
- rd_valid, out, 1, readout data valid.
- rd_data, out, see REQ-019, oldest stored entry.
- state, out, 2, current FSM state.
- count, out, CW, number of stored entries.
- overflow, out, 1, at least one pre-trigger entry was overwritten.

Function
REQ-003 A word SHALL be "accepted" when IR_valid=1 and not (filter_en=1 and IR[13:8] is 111110 or 111111).
REQ-004 The FSM SHALL have four states, encoded on the state output: IDLE=00, ARMED=01, POST=10, DONE=11.
REQ-005 arm=1 in any state SHALL clear count, pointers and overflow and enter ARMED next cycle. Arm has priority over every other input. A word accepted in the arm cycle SHALL NOT be stored.
REQ-006 In ARMED, each accepted word SHALL be written as an entry at the write pointer. The write pointer wraps modulo DEPTH. count saturates at DEPTH.
REQ-007 In ARMED with count=DEPTH, a write SHALL overwrite the oldest entry, advance the read pointer, and set overflow=1 (sticky until arm or reset).
REQ-008 In ARMED, an accepted word with IR[13:8]=trig_op SHALL be stored and move the FSM to POST. A stop pulse SHALL also move the FSM to POST; a word accepted in the same cycle as stop is stored.
REQ-009 On entry to POST, the post-trigger counter SHALL load post_cnt, sampled in the trigger cycle. If post_cnt=0 the FSM SHALL go directly to DONE instead of POST.
REQ-010 In POST, each accepted word SHALL be stored and decrement the counter. When the counter reaches 0, or when count reaches DEPTH, the FSM SHALL enter DONE. Entries are never overwritten in POST.
REQ-011 Latency: a word accepted in cycle N SHALL be reflected in count and in memory in cycle N+1.
REQ-012 In DONE, rd_valid SHALL equal (count!=0), and rd_data SHALL show the oldest entry combinationally from registered storage (first-word fall-through).
REQ-013 When rd_valid=1 and rd_ready=1, the read pointer SHALL advance modulo DEPTH and count SHALL decrement, both in the next cycle.
REQ-014 DONE SHALL be held after the buffer drains, until arm. Writes SHALL be ignored in DONE.
REQ-015 rd_valid SHALL be 0 in IDLE, ARMED and POST. rd_ready SHALL be ignored in those states.
REQ-016 stop SHALL be ignored in IDLE, POST and DONE. IR_valid SHALL be ignored in IDLE.
REQ-017 The opcode comparison SHALL use IR[13:8] for every IW_W.

Reset
REQ-018 While Reset_pin=1 at a rising edge, the following SHALL hold the next cycle: state=IDLE, count=0, overflow=0, pointers=0, post counter=0, timestamp=0, rd_valid=0. Memory contents are don't-care. A reset mid-capture or mid-readout SHALL discard the session.

Configuration
REQ-019 When macro TRACE_TIMESTAMP_EN is defined:
- a free-running TS_W counter SHALL increment every cycle and wrap to 0;
- each entry SHALL store the counter value from its accept cycle;
- rd_data SHALL be {TS, PC, IR}, width TS_W+PC_W+IW_W.
When the macro is undefined, there SHALL be no counter and rd_data SHALL be {PC, IR}, width PC_W+IW_W.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- Reset, then arm; 5 accepted words; trig_op matches the 6th word, post_cnt=2; 2 more words → state=DONE, count=8, overflow=0, readout returns the 8 words in order.
- Arm; 20 accepted words with no trigger; then stop → count=16, overflow=1, first rd_data = word #5.
- filter_en=1; stream interleaving NOP 0x3E00 and STALL 0x3F00 with 3 ADD words → only the 3 ADD words are stored.
- Trigger with post_cnt=0 → DONE the next cycle. Then rd_ready toggling 1,0,1 → one entry per ready-high cycle; rd_valid drops when count=0.
- Reset_pin=1 during POST with count=6 → state=00, count=0, rd_valid=0 the next cycle.
- With TRACE_TIMESTAMP_EN: words accepted in cycles 10 and 13 after reset → TS fields 10 and 13. At TS_W=4, the 17th cycle wraps to 0.

Source files
------------

// File: rtl/ast_trace_buffer.sv
// Instruction trace buffer: circular pre-trigger capture, post-trigger fill, FWFT readout.
// Optional macro TRACE_TIMESTAMP_EN adds a free-running timestamp stored with each entry.
module ast_trace_buffer #(
    parameter int IW_W  = 16,
    parameter int PC_W  = 16,
    parameter int DEPTH = 16,
    parameter int TS_W  = 16,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic            Clock_pin,
    input  logic            Reset_pin,
    input  logic            arm,
    input  logic            stop,
    input  logic [5:0]      trig_op,
    input  logic [CW-1:0]   post_cnt,
    input  logic            filter_en,
    input  logic [IW_W-1:0] IR,
    input  logic [PC_W-1:0] PC,
    input  logic            IR_valid,
    input  logic            rd_ready,
    output logic            rd_valid,
`ifdef TRACE_TIMESTAMP_EN
    output logic [TS_W+PC_W+IW_W-1:0] rd_data,
`else
    output logic [PC_W+IW_W-1:0]      rd_data,
`endif
    output logic [1:0]      state,
    output logic [CW-1:0]   count,
    output logic            overflow
);

`ifdef TRACE_TIMESTAMP_EN
    localparam int EW = TS_W + PC_W + IW_W;
`else
    localparam int EW = PC_W + IW_W;
`endif
    localparam int AW = $clog2(DEPTH);
    localparam logic [CW-1:0] Full = CW'(DEPTH);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StArmed = 2'b01,
        StPost  = 2'b10,
        StDone  = 2'b11
    } state_e;

    state_e        state_q, state_d;
    logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d, pcnt_q, pcnt_d;
    logic          ovf_q, ovf_d;
    logic          we;
    logic          accepted, is_trig, full;
    logic [EW-1:0] entry;
    logic [EW-1:0] mem_q [DEPTH];

    // NOP (111110) and STALL (111111) share IR[13:9] = 11111
    assign accepted = IR_valid && !(filter_en && (IR[13:9] == 5'b11111));
    assign is_trig  = (IR[13:8] == trig_op);
    assign full     = (count_q == Full);

`ifdef TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + 1'b1;
        end
    end

    assign entry = {ts_q, PC, IR};
`else
    logic unused_ts_w;
    assign unused_ts_w = ^TS_W;
    assign entry       = {PC, IR};
`endif

    always_comb begin
        state_d = state_q;
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        pcnt_d  = pcnt_q;
        ovf_d   = ovf_q;
        we      = 1'b0;
        if (arm) begin
            state_d = StArmed;
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
            pcnt_d  = '0;
            ovf_d   = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: ;
                StArmed: begin
                    if (accepted) begin
                        we     = 1'b1;
                        wptr_d = wptr_q + 1'b1;
                        if (full) begin
                            rptr_d = rptr_q + 1'b1;
                            ovf_d  = 1'b1;
                        end else begin
                            count_d = count_q + 1'b1;
                        end
                    end
                    if ((accepted && is_trig) || stop) begin
                        pcnt_d  = post_cnt;
                        state_d = (post_cnt == '0) ? StDone : StPost;
                    end
                end
                StPost: begin
                    if (full) begin
                        state_d = StDone;
                    end else if (accepted) begin
                        we      = 1'b1;
                        wptr_d  = wptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        pcnt_d  = pcnt_q - 1'b1;
                        if (pcnt_d == '0 || count_d == Full) begin
                            state_d = StDone;
                        end
                    end
                end
                StDone: begin
                    if (count_q != '0 && rd_ready) begin
                        rptr_d  = rptr_q + 1'b1;
                        count_d = count_q - 1'b1;
                    end
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge Clock_pin) begin
        if (Reset_pin) begin
            state_q <= StIdle;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            pcnt_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            pcnt_q  <= pcnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Storage has no reset; contents are qualified by count.
    always_ff @(posedge Clock_pin) begin
        if (we && !Reset_pin) begin
            mem_q[wptr_q] <= entry;
        end
    end

    assign rd_valid = (state_q == StDone) && (count_q != '0);
    assign rd_data  = mem_q[rptr_q];
    assign state    = state_q;
    assign count    = count_q;
    assign overflow = ovf_q;

endmodule
